// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_pkg
// Brief    : Shared types, constants and lane helper for the 1W1R SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
package sram_pkg;

    localparam int BYTE_W       = 8;
    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 2;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } sram_init_state_t;

    // One byte lane of a masked write: take the new lane when enabled.
    function automatic logic [BYTE_W-1:0] lane_merge(
        input logic [BYTE_W-1:0] old_lane,
        input logic [BYTE_W-1:0] new_lane,
        input logic              en
    );
        return en ? new_lane : old_lane;
    endfunction

endpackage : sram_pkg
`default_nettype wire

// File: rtl/sram_init_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_init_ctrl
// Brief    : Post-reset zero-fill sequencer; walks every address once.
// Revision : 1.0 - initial release
// ============================================================================
module sram_init_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_busy,
    output logic                  init_we,
    output logic [ADDR_WIDTH-1:0] init_addr
);

    localparam logic [ADDR_WIDTH-1:0] c_cnt_last = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] c_cnt_one  = ADDR_WIDTH'(1);

    sram_init_state_t      r_state;
    sram_init_state_t      w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        init_busy   = 1'b0;
        init_we     = 1'b0;
        init_addr   = r_cnt;
        case (r_state)
            ST_INIT: begin
                init_busy = 1'b1;
                init_we   = 1'b1;
                // The all-ones address is the last zero-fill; counter wraps back to 0.
                if (r_cnt == c_cnt_last) begin
                    w_state_nxt = ST_READY;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_cnt_one;
                end
            end
            ST_READY: begin
                w_state_nxt = ST_READY;
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule : sram_init_ctrl
`default_nettype wire

// File: rtl/sram_1w1r_init_bwe.sv
`default_nettype none
// ============================================================================
// Module   : sram_1w1r_init_bwe
// Brief    : 1W1R register-array SRAM with byte mask, 1/2-cycle read latency,
//            selectable collision behaviour and post-reset zero fill.
// Revision : 1.0 - initial release
// ============================================================================
module sram_1w1r_init_bwe
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_FIRST  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         csb0,
    input  logic [DATA_WIDTH/BYTE_W-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]        addr0,
    input  logic [DATA_WIDTH-1:0]        din0,
    input  logic                         csb1,
    input  logic [ADDR_WIDTH-1:0]        addr1,
    output logic [DATA_WIDTH-1:0]        dout1,
    output logic                         dout1_valid,
    output logic                         init_busy
);

    localparam int c_ram_depth = 1 << ADDR_WIDTH;
    localparam int c_lanes     = DATA_WIDTH / BYTE_W;

    if ((DATA_WIDTH % BYTE_W) != 0) begin : g_chk_data_width
        $fatal(1, "sram_1w1r_init_bwe: DATA_WIDTH must be a multiple of 8");
    end
    if ((READ_LATENCY < READ_LAT_MIN) || (READ_LATENCY > READ_LAT_MAX)) begin : g_chk_read_latency
        $fatal(1, "sram_1w1r_init_bwe: READ_LATENCY must be 1 or 2");
    end

    logic [DATA_WIDTH-1:0] r_mem [c_ram_depth];

    logic                  w_init_busy;
    logic                  w_init_we;
    logic [ADDR_WIDTH-1:0] w_init_addr;

    sram_init_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init_ctrl (
        .clk       (clk),
        .rst       (rst),
        .init_busy (w_init_busy),
        .init_we   (w_init_we),
        .init_addr (w_init_addr)
    );

    assign init_busy = w_init_busy;

    logic                  w_user_wr;
    logic                  w_rd_req;
    logic                  w_wr_en;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_old_wr;
    logic [DATA_WIDTH-1:0] w_old_rd;
    logic [DATA_WIDTH-1:0] w_wr_word;
    logic [DATA_WIDTH-1:0] w_fwd_word;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_collide;

    assign w_user_wr = !csb0 && !w_init_busy;
    assign w_rd_req  = !csb1 && !w_init_busy;
    assign w_wr_en   = w_init_we || w_user_wr;
    assign w_wr_addr = w_init_we ? w_init_addr : addr0;
    assign w_old_wr  = r_mem[w_wr_addr];
    assign w_old_rd  = r_mem[addr1];

    for (genvar i = 0; i < c_lanes; i++) begin : g_lane
        assign w_wr_word[i*BYTE_W +: BYTE_W] = w_init_we ? '0 :
            lane_merge(w_old_wr[i*BYTE_W +: BYTE_W], din0[i*BYTE_W +: BYTE_W], wmask0[i]);
        assign w_fwd_word[i*BYTE_W +: BYTE_W] =
            lane_merge(w_old_rd[i*BYTE_W +: BYTE_W], din0[i*BYTE_W +: BYTE_W], wmask0[i]);
    end

    assign w_collide = w_user_wr && (addr0 == addr1);
    assign w_rd_word = ((WRITE_FIRST != 0) && w_collide) ? w_fwd_word : w_old_rd;

    // Array itself is not reset; the zero-fill sequencer defines its contents.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_word;
        end
    end

    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_rd_req;
            if (w_rd_req) begin
                r_s1_data <= w_rd_word;
            end
        end
    end

    if (READ_LATENCY == 1) begin : g_lat1
        assign dout1       = r_s1_data;
        assign dout1_valid = r_s1_valid;
    end else begin : g_lat2
        logic                  r_s2_valid;
        logic [DATA_WIDTH-1:0] r_s2_data;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_s2_valid <= 1'b0;
                r_s2_data  <= '0;
            end else begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= r_s1_data;
                end
            end
        end

        assign dout1       = r_s2_data;
        assign dout1_valid = r_s2_valid;
    end

endmodule : sram_1w1r_init_bwe
`default_nettype wire

// File: tb/tb_sram_1w1r_init_bwe.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_1w1r_init_bwe
// Brief    : Bench for two SRAM configurations (RL1/write-first and
//            RL2/read-first) against a word-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_1w1r_init_bwe;

    logic        clk = 1'b0;
    logic        rst;
    logic        csb0;
    logic [3:0]  wmask0;
    logic [7:0]  addr0;
    logic [31:0] din0;
    logic        csb1;
    logic [7:0]  addr1;
    logic [31:0] dout_a, dout_b;
    logic        valid_a, valid_b, busy_a, busy_b;

    always #5 clk = ~clk;

    sram_1w1r_init_bwe #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_LATENCY(1), .WRITE_FIRST(1)
    ) u_dut_a (
        .clk(clk), .rst(rst), .csb0(csb0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .csb1(csb1), .addr1(addr1), .dout1(dout_a), .dout1_valid(valid_a), .init_busy(busy_a)
    );

    sram_1w1r_init_bwe #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_LATENCY(2), .WRITE_FIRST(0)
    ) u_dut_b (
        .clk(clk), .rst(rst), .csb0(csb0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .csb1(csb1), .addr1(addr1), .dout1(dout_b), .dout1_valid(valid_b), .init_busy(busy_b)
    );

    // Reference model: word array, remaining zero-fill cycles, output expectations.
    logic [31:0] m_mem [256];
    int          m_init_left;
    logic [31:0] exp_a_d, exp_b_d, pend_d;
    logic        exp_a_v, exp_b_v, pend_v;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [31:0] old_w, new_w, rd_wf, rd_rf;
        logic        req;
        if (rst) begin
            m_init_left = 256;
            exp_a_v = 1'b0; exp_a_d = '0;
            exp_b_v = 1'b0; exp_b_d = '0;
            pend_v  = 1'b0; pend_d  = '0;
        end else begin
            req = 1'b0; rd_wf = '0; rd_rf = '0;
            if (m_init_left > 0) begin
                m_mem[256 - m_init_left] = '0;
                m_init_left--;
            end else begin
                old_w = m_mem[addr1];
                new_w = m_mem[addr0];
                for (int b = 0; b < 4; b++)
                    if (wmask0[b]) new_w[8*b +: 8] = din0[8*b +: 8];
                req   = !csb1;
                rd_rf = old_w;
                rd_wf = (!csb0 && addr0 == addr1) ? new_w : old_w;
                if (!csb0) m_mem[addr0] = new_w;
            end
            exp_a_v = req;
            if (req) exp_a_d = rd_wf;
            exp_b_v = pend_v;
            if (pend_v) exp_b_d = pend_d;
            pend_v = req;
            pend_d = rd_rf;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("a_dout",  dout_a,  exp_a_d);
        chk("a_valid", {31'd0, valid_a}, {31'd0, exp_a_v});
        chk("a_busy",  {31'd0, busy_a},  {31'd0, m_init_left > 0});
        chk("b_dout",  dout_b,  exp_b_d);
        chk("b_valid", {31'd0, valid_b}, {31'd0, exp_b_v});
        chk("b_busy",  {31'd0, busy_b},  {31'd0, m_init_left > 0});
    endtask

    task automatic idle();
        csb0 = 1'b1; csb1 = 1'b1;
        cyc();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
        csb0 = 1'b0; addr0 = a; din0 = d; wmask0 = m; csb1 = 1'b1;
        cyc();
        csb0 = 1'b1;
    endtask

    task automatic rd(input logic [7:0] a);
        csb1 = 1'b0; addr1 = a; csb0 = 1'b1;
        cyc();
        csb1 = 1'b1;
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 400 && busy_a; k++) idle();
        chk("ready_timeout", {31'd0, busy_a}, 32'd0);
    endtask

    int          busy_cnt;
    logic [31:0] tp_d [6];
    logic        tp_v [6];

    initial begin
        rst = 1'b1; csb0 = 1'b1; csb1 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0; addr1 = '0;
        cyc();
        rst = 1'b0;

        // Init length, plus a read during busy that must be dropped.
        busy_cnt = 0;
        for (int k = 0; k < 400 && busy_a; k++) begin
            busy_cnt++;
            csb1  = (k == 5) ? 1'b0 : 1'b1;
            addr1 = 8'hFF;
            cyc();
        end
        csb1 = 1'b1;
        chk("init_busy_len", busy_cnt, 32'd256);
        rd(8'hFF);
        chk("init_zero_ff", dout_a, 32'h0);
        chk("init_zero_ff_v", {31'd0, valid_a}, 32'd1);

        // Byte-lane mask.
        wr(8'h10, 32'hAABBCCDD, 4'b1111);
        wr(8'h10, 32'h11223344, 4'b0101);
        rd(8'h10);
        chk("bmask_rl1", dout_a, 32'hAA22CC44);
        idle();
        chk("bmask_rl2", dout_b, 32'hAA22CC44);

        // Same-address collision.
        csb0 = 1'b0; addr0 = 8'h20; din0 = 32'hDEADBEEF; wmask0 = 4'b1111;
        csb1 = 1'b0; addr1 = 8'h20;
        cyc();
        chk("coll_wf1", dout_a, 32'hDEADBEEF);
        idle();
        chk("coll_wf0", dout_b, 32'h0);

        // Back-to-back reads through the 2-cycle pipeline.
        for (int k = 1; k <= 4; k++) wr(8'(k), 32'(k), 4'b1111);
        for (int k = 0; k < 6; k++) begin
            csb1 = (k < 4) ? 1'b0 : 1'b1;
            addr1 = 8'(k + 1);
            cyc();
            tp_v[k] = valid_b;
            tp_d[k] = dout_b;
        end
        for (int k = 0; k < 6; k++) begin
            chk("tput_valid", {31'd0, tp_v[k]}, {31'd0, (k >= 1 && k <= 4)});
            if (k >= 1 && k <= 4) chk("tput_data", tp_d[k], 32'(k));
        end

        // Hold after a single read.
        wr(8'h30, 32'h5, 4'b1111);
        rd(8'h30);
        chk("hold_first", dout_a, 32'h5);
        for (int k = 0; k < 10; k++) idle();
        chk("hold_data", dout_a, 32'h5);
        chk("hold_valid", {31'd0, valid_a}, 32'd0);

        // Randomised traffic on a narrow address range to provoke collisions.
        for (int k = 0; k < 1500; k++) begin
            csb0   = 1'($urandom_range(0, 1));
            csb1   = 1'($urandom_range(0, 1));
            addr0  = 8'($urandom_range(0, 7));
            addr1  = 8'($urandom_range(0, 7));
            din0   = $urandom;
            wmask0 = 4'($urandom);
            cyc();
        end
        csb0 = 1'b1; csb1 = 1'b1;

        // Reset while a read is in flight.
        wr(8'h10, 32'h12345678, 4'b1111);
        rd(8'h10);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_mid_valid_b", {31'd0, valid_b}, 32'd0);
        chk("rst_mid_dout_b", dout_b, 32'h0);
        chk("rst_mid_busy", {31'd0, busy_a}, 32'd1);
        wait_ready();
        rd(8'h10);
        chk("rst_mid_zero", dout_a, 32'h0);
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sram_1w1r_init_bwe
`default_nettype wire
